// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter
// Merges NUM_OF_INGRESS_PORTS AXI-Stream ingress ports onto a single egress using
// round-robin arbitration with packet granularity. A grant is held from the first
// beat of a packet until its tlast beat is accepted, so packets never interleave.
// Egress beats pass through a registered slice (1-cycle latency). The slice tags
// each beat's tuser with the source port id.

module axis_pkt_rr_arbiter #(
    parameter int DATA_SIZE            = 32,
    parameter int USER_SIZE            = 16,
    parameter int NUM_OF_INGRESS_PORTS = 3,
    localparam int PORT_ID_W = (NUM_OF_INGRESS_PORTS > 2) ? $clog2(NUM_OF_INGRESS_PORTS) : 1,
    localparam int KEEP_SIZE = DATA_SIZE / 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_OF_INGRESS_PORTS-1:0]           cfg_port_en,
    input  logic [NUM_OF_INGRESS_PORTS-1:0]           s_tvalid,
    output logic [NUM_OF_INGRESS_PORTS-1:0]           s_tready,
    input  logic [NUM_OF_INGRESS_PORTS*DATA_SIZE-1:0] s_tdata,
    input  logic [NUM_OF_INGRESS_PORTS*KEEP_SIZE-1:0] s_tkeep,
    input  logic [NUM_OF_INGRESS_PORTS-1:0]           s_tlast,
    output logic                                      m_tvalid,
    input  logic                                      m_tready,
    output logic [DATA_SIZE-1:0]                      m_tdata,
    output logic [KEEP_SIZE-1:0]                      m_tkeep,
    output logic                                      m_tlast,
    output logic [USER_SIZE-1:0]                      m_tuser,
    output logic                                      grant_active,
    output logic [PORT_ID_W-1:0]                      grant_port,
    output logic [31:0]                               pkt_cnt
);

    localparam logic [PORT_ID_W-1:0] LAST_PORT  = PORT_ID_W'(NUM_OF_INGRESS_PORTS - 1);
    localparam logic [PORT_ID_W:0]   NUM_PORTS_W = (PORT_ID_W + 1)'(NUM_OF_INGRESS_PORTS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Port following p in round-robin order, wrapping N-1 -> 0.
    function automatic logic [PORT_ID_W-1:0] next_port(input logic [PORT_ID_W-1:0] p);
        logic [PORT_ID_W-1:0] n;
        if (p == LAST_PORT) begin
            n = '0;
        end else begin
            n = p + PORT_ID_W'(1);
        end
        return n;
    endfunction

    state_t                   state_q,      state_d;
    logic [PORT_ID_W-1:0]     rr_ptr_q,     rr_ptr_d;
    logic [PORT_ID_W-1:0]     grant_port_q, grant_port_d;
    logic                     m_tvalid_q,   m_tvalid_d;
    logic [DATA_SIZE-1:0]     m_tdata_q,    m_tdata_d;
    logic [KEEP_SIZE-1:0]     m_tkeep_q,    m_tkeep_d;
    logic                     m_tlast_q,    m_tlast_d;
    logic [USER_SIZE-1:0]     m_tuser_q,    m_tuser_d;
    logic [31:0]              pkt_cnt_q,    pkt_cnt_d;

    logic [NUM_OF_INGRESS_PORTS-1:0] req_s;
    logic [NUM_OF_INGRESS_PORTS-1:0] s_tready_s;
    logic                            found_s;
    logic [PORT_ID_W-1:0]            winner_s;
    logic                            sel_valid_s;
    logic                            sel_last_s;
    logic [DATA_SIZE-1:0]            sel_data_s;
    logic [KEEP_SIZE-1:0]            sel_keep_s;
    logic                            slice_free_s;
    logic                            in_hs_s;
    logic                            out_hs_s;

    // Round-robin search: first enabled requester at or after rr_ptr, modulo N.
    always_comb begin
        logic [PORT_ID_W:0] sum_v;
        logic [PORT_ID_W:0] idx_v;
        logic               hit_v;
        req_s    = s_tvalid & cfg_port_en;
        found_s  = 1'b0;
        winner_s = '0;
        sum_v    = '0;
        idx_v    = '0;
        hit_v    = 1'b0;
        for (int i = 0; i < NUM_OF_INGRESS_PORTS; i++) begin
            sum_v    = {1'b0, rr_ptr_q} + (PORT_ID_W + 1)'(i);
            idx_v    = (sum_v >= NUM_PORTS_W) ? (sum_v - NUM_PORTS_W) : sum_v;
            hit_v    = ~found_s & req_s[idx_v[PORT_ID_W-1:0]];
            winner_s = hit_v ? idx_v[PORT_ID_W-1:0] : winner_s;
            found_s  = found_s | hit_v;
        end
    end

    // Mux the granted port's ingress fields and derive both handshakes.
    always_comb begin
        sel_valid_s  = s_tvalid[grant_port_q];
        sel_last_s   = s_tlast[grant_port_q];
        sel_data_s   = s_tdata[int'(grant_port_q) * DATA_SIZE +: DATA_SIZE];
        sel_keep_s   = s_tkeep[int'(grant_port_q) * KEEP_SIZE +: KEEP_SIZE];
        slice_free_s = ~m_tvalid_q | m_tready;
        in_hs_s      = (state_q == ST_GRANT) & sel_valid_s & slice_free_s;
        out_hs_s     = m_tvalid_q & m_tready;
    end

    // Ingress ready: only the granted port, only while the output slice can take a beat.
    always_comb begin
        s_tready_s = '0;
        if (state_q == ST_GRANT) begin
            s_tready_s[grant_port_q] = slice_free_s;
        end else begin
            s_tready_s = '0;
        end
    end

    // Arbitration FSM: pick a port in IDLE, hold it in GRANT until its tlast is accepted.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_port_d = grant_port_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_port_d = winner_s;
                    state_d      = ST_GRANT;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (in_hs_s && sel_last_s) begin
                    rr_ptr_d = next_port(grant_port_q);
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output slice: load on ingress handshake, otherwise empty when drained, otherwise hold.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        if (in_hs_s) begin
            m_tvalid_d                   = 1'b1;
            m_tdata_d                    = sel_data_s;
            m_tkeep_d                    = sel_keep_s;
            m_tlast_d                    = sel_last_s;
            m_tuser_d                    = '0;
            m_tuser_d[PORT_ID_W-1:0]     = grant_port_q;
        end else if (out_hs_s) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // Completed-packet counter: counts egress tlast handshakes, wraps naturally.
    always_comb begin
        if (out_hs_s && m_tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_port_q <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= '0;
            pkt_cnt_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_port_q <= grant_port_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign s_tready     = s_tready_s;
    assign m_tvalid     = m_tvalid_q;
    assign m_tdata      = m_tdata_q;
    assign m_tkeep      = m_tkeep_q;
    assign m_tlast      = m_tlast_q;
    assign m_tuser      = m_tuser_q;
    assign grant_active = (state_q == ST_GRANT);
    assign grant_port   = grant_port_q;
    assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Testbench for axis_pkt_rr_arbiter: randomized per-port packet sources, a
// behavioural reference model compared every cycle, an egress scoreboard that
// checks packet contents/ordering, and directed scenarios with literal results.

module tb_axis_pkt_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 16;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    cfg_port_en;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic            grant_active;
    logic [PW-1:0]   grant_port;
    logic [31:0]     pkt_cnt;

    axis_pkt_rr_arbiter #(
        .DATA_SIZE(DW), .USER_SIZE(UW), .NUM_OF_INGRESS_PORTS(N)
    ) dut (
        .clk(clk), .rst(rst), .cfg_port_en(cfg_port_en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant_active(grant_active), .grant_port(grant_port), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus control ----------------
    int           vprob;      // percent chance an idle source presents a beat
    int           rmode;      // 0: m_tready=1, 1: toggle, 2: random
    int           fixed_len;  // >0 fixed packet length, 0 pseudo-random length
    logic [N-1:0] allow;      // which sources may present beats
    bit           rtog = 1'b0;
    bit           chk_en = 1'b0;

    int src_pkt [N];
    int src_beat[N];
    bit src_v   [N];
    bit hs_rec  [N];

    function automatic int pkt_len(input int p, input int pk);
        if (fixed_len > 0) return fixed_len;
        return ((pk * 7 + p * 3) % 5) + 1;
    endfunction

    function automatic logic [DW-1:0] beat_word(input int p, input int pk, input int bt);
        return {4'(p), 12'(pk), 16'(bt)};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input bit last, input int pk);
        return last ? 4'((pk % 15) + 1) : 4'hF;
    endfunction

    task automatic drive_inputs();
        bit last;
        for (int p = 0; p < N; p++) begin
            last = (src_beat[p] == pkt_len(p, src_pkt[p]) - 1);
            s_tvalid[p]          = src_v[p];
            s_tdata[p*DW +: DW]  = beat_word(p, src_pkt[p], src_beat[p]);
            s_tkeep[p*KW +: KW]  = beat_keep(last, src_pkt[p]);
            s_tlast[p]           = last;
        end
    endtask

    // One clock: record ingress handshakes before the edge, then update sources after it.
    task automatic step();
        @(negedge clk);
        for (int p = 0; p < N; p++) hs_rec[p] = s_tvalid[p] & s_tready[p];
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (hs_rec[p]) begin
                src_v[p] = 1'b0;
                if (src_beat[p] == pkt_len(p, src_pkt[p]) - 1) begin
                    src_pkt[p]++;
                    src_beat[p] = 0;
                end else begin
                    src_beat[p]++;
                end
            end
            if (!src_v[p]) src_v[p] = allow[p] && ($urandom_range(0, 99) < vprob);
        end
        case (rmode)
            0: m_tready = 1'b1;
            1: begin rtog = ~rtog; m_tready = rtog; end
            default: m_tready = ($urandom_range(0, 99) < 70);
        endcase
        drive_inputs();
    endtask

    // ---------------- reference model (updated at each rising edge) ----------------
    bit            e_busy;
    int            e_port;
    int            e_ptr;
    bit            e_mv;
    logic [DW-1:0] e_md;
    logic [KW-1:0] e_mk;
    bit            e_ml;
    int            e_mu;
    logic [31:0]   e_cnt;

    initial begin
        forever begin
            bit           rdy, hs, drain, found;
            logic [N-1:0] req;
            int           p;
            @(posedge clk);
            if (rst) begin
                e_busy = 0; e_port = 0; e_ptr = 0; e_mv = 0; e_md = '0;
                e_mk = '0; e_ml = 0; e_mu = 0; e_cnt = 32'd0;
            end else begin
                rdy   = e_busy && (!e_mv || m_tready);
                hs    = rdy && s_tvalid[e_port];
                drain = e_mv && m_tready;
                if (drain && e_ml) e_cnt = e_cnt + 32'd1;
                if (hs) begin
                    e_mv = 1;
                    e_md = s_tdata[e_port*DW +: DW];
                    e_mk = s_tkeep[e_port*KW +: KW];
                    e_ml = s_tlast[e_port];
                    e_mu = e_port;
                end else if (drain) begin
                    e_mv = 0;
                end
                if (!e_busy) begin
                    req   = s_tvalid & cfg_port_en;
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        p = (e_ptr + k) % N;
                        if (!found && req[p]) begin
                            found  = 1;
                            e_port = p;
                            e_busy = 1;
                        end
                    end
                end else if (hs && s_tlast[e_port]) begin
                    e_ptr  = (e_port + 1) % N;
                    e_busy = 0;
                end
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int   sb_pkt [N];
    int   sb_beat[N];
    bit   sb_open;
    int   sb_cur;
    int   order_q[$];
    int   beat_q [$];
    bit   prev_stall;
    logic [63:0] prev_bus;

    // Compare process: DUT versus model every cycle, plus egress content and AXIS stability.
    initial begin
        forever begin
            logic [N-1:0] er;
            int           port;
            bit           exp_last;
            @(negedge clk);
            if (chk_en) begin
                er = '0;
                if (e_busy && (!e_mv || m_tready)) er[e_port] = 1'b1;
                chk("m_tvalid", m_tvalid, e_mv);
                chk("m_tdata", m_tdata, e_md);
                chk("m_tkeep", m_tkeep, e_mk);
                chk("m_tlast", m_tlast, e_ml);
                chk("m_tuser", m_tuser, e_mu);
                chk("s_tready", s_tready, er);
                chk("grant_active", grant_active, e_busy);
                chk("grant_port", grant_port, e_port);
                chk("pkt_cnt", pkt_cnt, e_cnt);
                if (!rst && prev_stall)
                    chk("stall_stable", {9'b0, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, prev_bus);
                if (!rst && m_tvalid && m_tready) begin
                    port = int'(m_tuser);
                    if (port < N) begin
                        exp_last = (sb_beat[port] == pkt_len(port, sb_pkt[port]) - 1);
                        chk("sb_data", m_tdata, beat_word(port, sb_pkt[port], sb_beat[port]));
                        chk("sb_last", m_tlast, exp_last);
                        if (sb_open) chk("no_interleave", port, sb_cur);
                        beat_q.push_back(port);
                        sb_cur  = port;
                        sb_open = !m_tlast;
                        if (m_tlast) begin
                            order_q.push_back(port);
                            sb_pkt[port]++;
                            sb_beat[port] = 0;
                        end else begin
                            sb_beat[port]++;
                        end
                    end else begin
                        chk("sb_port_range", port, 0);
                    end
                end
                prev_stall = m_tvalid && !m_tready && !rst;
                prev_bus   = {9'b0, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};
            end
        end
    end

    // Reset for 3 edges with new stimulus settings; optionally pin the reset state.
    task automatic do_reset(input int vp, input int rm, input int fl,
                            input logic [N-1:0] al, input logic [N-1:0] en, input bit lits);
        rst = 1'b1;
        vprob = vp; rmode = rm; fixed_len = fl; allow = al; cfg_port_en = en;
        m_tready = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_v[p] = 0; src_pkt[p] = 0; src_beat[p] = 0; hs_rec[p] = 0;
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (lits) begin
            chk("rst_m_tvalid", m_tvalid, 1'b0);
            chk("rst_m_tlast", m_tlast, 1'b0);
            chk("rst_m_tdata", m_tdata, 32'h0);
            chk("rst_m_tuser", m_tuser, 16'h0);
            chk("rst_s_tready", s_tready, 3'b000);
            chk("rst_grant_active", grant_active, 1'b0);
            chk("rst_grant_port", grant_port, 2'd0);
            chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            sb_pkt[p] = 0; sb_beat[p] = 0;
        end
        sb_open = 0; sb_cur = 0; prev_stall = 0;
        order_q.delete();
        beat_q.delete();
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int c = 0;
        while (order_q.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(name, order_q.size() >= n, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lead;
        int hs_cnt;
        int p1_beats;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        m_tready = 1'b1; cfg_port_en = 3'b111;

        // Initial reset, then port0 starts an 8-beat packet; reset lands mid-packet.
        do_reset(100, 0, 8, 3'b001, 3'b111, 1'b1);
        repeat (4) step();
        chk("t1_mid_grant", grant_active, 1'b1);
        chk("t1_mid_valid", m_tvalid, 1'b1);
        chk("t1_mid_cnt", pkt_cnt, 32'd0);

        // Round-robin with all ports continuously valid, 4-beat packets.
        do_reset(100, 0, 4, 3'b111, 3'b111, 1'b1);
        run_until(6, 200, "t2_timeout");
        for (int i = 0; i < 6 && i < order_q.size(); i++) chk("t2_order", order_q[i], i % 3);
        step();
        chk("t2_pkt_cnt", pkt_cnt, 32'd6);

        // No interleave: port0 8-beat packet while port1 is also valid.
        do_reset(100, 0, 8, 3'b011, 3'b111, 1'b0);
        begin
            int c = 0;
            while (beat_q.size() < 9 && c < 100) begin step(); c++; end
        end
        chk("t3_timeout", beat_q.size() >= 9, 1'b1);
        lead = 0;
        while (lead < beat_q.size() && beat_q[lead] == 0) lead++;
        chk("t3_contig", lead, 8);
        if (beat_q.size() > 8) chk("t3_next_port", beat_q[8], 1);

        // Backpressure: m_tready toggling, random packet lengths.
        do_reset(80, 1, 0, 3'b111, 3'b111, 1'b0);
        repeat (300) step();
        chk("t4_progress", order_q.size() >= 10, 1'b1);

        // Mask 101: port1 never granted.
        do_reset(100, 0, 2, 3'b111, 3'b101, 1'b0);
        run_until(4, 100, "t5_timeout");
        if (order_q.size() >= 4) begin
            chk("t5_order0", order_q[0], 0);
            chk("t5_order1", order_q[1], 2);
            chk("t5_order2", order_q[2], 0);
            chk("t5_order3", order_q[3], 2);
        end
        repeat (50) step();
        p1_beats = 0;
        foreach (beat_q[i]) if (beat_q[i] == 1) p1_beats++;
        chk("t5_port1_beats", p1_beats, 0);

        // Single-beat packets from port2 only: one beat every two cycles.
        do_reset(100, 0, 1, 3'b100, 3'b111, 1'b0);
        repeat (4) step();
        hs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hs_rec[2]) hs_cnt++;
            chk("t6_grant_port", grant_port, 2'd2);
        end
        chk("t6_beats_in_20", hs_cnt, 10);

        // Random traffic, random backpressure, mask changes at arbitrary times.
        do_reset(60, 2, 0, 3'b111, 3'b111, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i % 50 == 49) cfg_port_en = 3'($urandom_range(0, 7));
        end
        chk("t7_progress", order_q.size() >= 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
